// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// Define UART_TX_ARB_HDR_EN to emit one header beat (gnt_id with MSB set) at the start of each grant.
module uart_tx_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    localparam int GNT_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic [GNT_W-1:0]              gnt_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef UART_TX_ARB_HDR_EN
        ST_HDR  = 2'd1,
`endif
        ST_XFER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   ptr_q, ptr_d;
    logic [GNT_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    logic                  sel_found;
    logic [GNT_W-1:0]      sel_id;
    logic [GNT_W-1:0]      scan_idx;
    logic                  burst_done;
    logic                  beat_acc;

    function automatic logic [GNT_W-1:0] wrap_inc(input logic [GNT_W-1:0] v);
        return (v == GNT_W'(NUM_REQ - 1)) ? '0 : v + GNT_W'(1);
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_id    = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // Compared against MAX_BURST-1 so the beat that reaches the limit releases the grant.
    assign burst_done = (MAX_BURST != 0) && (cnt_q == CNT_W'(MAX_BURST - 1));

`ifdef UART_TX_ARB_HDR_EN
    logic [DATA_WIDTH-1:0] hdr_beat;
    always_comb begin
        hdr_beat                 = '0;
        hdr_beat[GNT_W-1:0]      = gnt_q;
        hdr_beat[DATA_WIDTH-1]   = 1'b1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        beat_acc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    gnt_d = sel_id;
                    cnt_d = '0;
`ifdef UART_TX_ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_XFER;
`endif
                end
            end
`ifdef UART_TX_ARB_HDR_EN
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_beat;
                if (tx_ready) begin
                    state_d = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                tx_valid         = req_valid[gnt_q];
                tx_data          = req_data_arr[gnt_q];
                req_ready[gnt_q] = tx_ready;
                beat_acc         = req_valid[gnt_q] && tx_ready;
                if (beat_acc) begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    if (req_last[gnt_q] || burst_done) begin
                        state_d = ST_IDLE;
                        ptr_d   = wrap_inc(gnt_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_id = gnt_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic against a
// grant-level reference model and per-requester data scoreboards.
`timescale 1ns/1ps
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
`ifdef UART_TX_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_valid;
    logic [DW-1:0]        tx_data;
    logic                 tx_ready;
    logic [1:0]           gnt_id;
    logic                 busy;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .gnt_id(gnt_id), .busy(busy)
    );

    typedef struct { logic [7:0] d; logic l; } beat_t;
    typedef struct { int id; logic [7:0] d; int cyc; } obs_t;

    beat_t      srcq [NREQ][$];
    logic [7:0] expq [NREQ][$];
    bit         held [NREQ];
    obs_t       dlog [$];
    logic [7:0] txs  [$];
    logic       busy_hist [8192];

    int checks = 0, failures = 0, cyc = 0, vrate = 100, rrate = 100;
    int m_st = 0, m_gnt = 0, m_ptr = 0, m_cnt = 0;   // 0 idle, 1 header, 2 data

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0 && (held[i] || $urandom_range(99) < vrate)) begin
                held[i]              = 1'b1;
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = srcq[i][0].d;
                req_last[i]          = srcq[i][0].l;
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = 8'($urandom);
                req_last[i]          = 1'($urandom);
            end
        end
        tx_ready = ($urandom_range(99) < rrate);
    endtask

    task automatic push_beat(input int i, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        srcq[i].push_back(b);
        expq[i].push_back(d);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (srcq[i].size() != 0 || expq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: compare against the model at negedge, advance the model, re-drive after posedge.
    task automatic step();
        logic [NREQ-1:0] e_ready;
        logic            e_valid, e_busy, e_last;
        logic [7:0]      e_data;
        obs_t            o;
        int              g;
        @(negedge clk);
        e_valid = 1'b0; e_data = 8'h00; e_ready = '0; e_busy = (m_st != 0); e_last = 1'b0;
        if (m_st == 1) begin
            e_valid = 1'b1;
            e_data  = 8'h80 | 8'(m_gnt);
        end else if (m_st == 2) begin
            e_valid        = req_valid[m_gnt];
            e_data         = req_data[m_gnt*DW +: DW];
            e_ready[m_gnt] = tx_ready;
            e_last         = req_last[m_gnt];
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
        chk("tx_valid", 32'(tx_valid), 32'(e_valid));
        chk("tx_data", 32'(tx_data), 32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        if (cyc < 8192) busy_hist[cyc] = busy;
        if (!rst && tx_valid === 1'b1 && tx_ready) begin
            txs.push_back(tx_data);
            if (|req_ready && !$isunknown(gnt_id)) begin
                g     = int'(gnt_id);
                o.id  = g;
                o.d   = tx_data;
                o.cyc = cyc;
                dlog.push_back(o);
                chk("sb_unexpected_beat", 32'(expq[g].size() != 0), 32'd1);
                if (expq[g].size() != 0) chk("sb_data", 32'(tx_data), 32'(expq[g].pop_front()));
            end
        end
        if (rst) begin
            m_st = 0; m_ptr = 0; m_gnt = 0; m_cnt = 0;
        end else if (m_st == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_st == 0 && req_valid[c]) begin
                    m_gnt = c;
                    m_cnt = 0;
                    m_st  = (HDR != 0) ? 1 : 2;
                end
            end
        end else if (m_st == 1) begin
            if (tx_ready) m_st = 2;
        end else if (e_valid && tx_ready) begin
            srcq[m_gnt].delete(0);
            held[m_gnt] = 1'b0;
            m_cnt++;
            if (e_last || m_cnt == MAXB) begin
                m_st  = 0;
                m_ptr = (m_gnt + 1) % NREQ;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        drive_sources();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            srcq[i].delete();
            expq[i].delete();
            held[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        drive_sources();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] t1d [3];
        int         t3id [8];
        logic [7:0] t3d [8];
        int         pat [7];
        int         t0;
        t1d  = '{8'h11, 8'h22, 8'h33};
        t3id = '{0, 0, 0, 0, 2, 2, 0, 0};
        t3d  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hC0, 8'hC1, 8'hA4, 8'hA5};
        pat  = '{1, 0, 0, 1, 1, 1, 1};
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, three beats back to back
        do_reset();
        dlog.delete();
        push_beat(1, 8'h11, 1'b0); push_beat(1, 8'h22, 1'b0); push_beat(1, 8'h33, 1'b1);
        drive_sources();
        t0 = cyc;
        repeat (6 + HDR) step();
        chk("t1_count", 32'(dlog.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (dlog.size() > k) begin
                chk("t1_id", 32'(dlog[k].id), 32'd1);
                chk("t1_data", 32'(dlog[k].d), 32'(t1d[k]));
                chk("t1_cycle", 32'(dlog[k].cyc), 32'(t0 + 1 + HDR + k));
            end
        end
        chk("t1_busy_arb", 32'(busy_hist[t0]), 32'd0);
        chk("t1_busy_gnt", 32'(busy_hist[t0 + 1]), 32'd1);
        chk("t1_busy_end", 32'(busy_hist[t0 + 4 + HDR]), 32'd0);

        // Contention: every requester valid with single-beat packets
        do_reset();
        dlog.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) push_beat(i, 8'(8'h40 + r*4 + i), 1'b1);
        drive_sources();
        repeat (26) step();
        chk("t2_count", 32'(dlog.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (dlog.size() > k) begin
                chk("t2_order", 32'(dlog[k].id), 32'(k % NREQ));
                if (k > 0) chk("t2_spacing", 32'(dlog[k].cyc - dlog[k-1].cyc), 32'(2 + HDR));
            end
        end

        // Burst limit forces rotation to the waiting requester
        do_reset();
        dlog.delete();
        for (int k = 0; k < 6; k++) push_beat(0, 8'(8'hA0 + k), k == 5);
        push_beat(2, 8'hC0, 1'b0); push_beat(2, 8'hC1, 1'b1);
        drive_sources();
        repeat (20) step();
        chk("t3_count", 32'(dlog.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (dlog.size() > k) begin
                chk("t3_id", 32'(dlog[k].id), 32'(t3id[k]));
                chk("t3_data", 32'(dlog[k].d), 32'(t3d[k]));
            end
        end

        // Backpressure pattern on the transmitter side
        do_reset();
        dlog.delete();
        push_beat(1, 8'h71, 1'b0); push_beat(1, 8'h72, 1'b0); push_beat(1, 8'h73, 1'b1);
        drive_sources();
        step();
        for (int k = 0; k < 7; k++) begin
            tx_ready = pat[k][0];
            step();
        end
        repeat (3) step();
        chk("t4_count", 32'(dlog.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (dlog.size() > k) chk("t4_data", 32'(dlog[k].d), 32'(8'h71 + k));

        // Reset in the middle of a packet, with ptr left pointing past requester 1
        dlog.delete();
        for (int k = 0; k < 5; k++) push_beat(2, 8'(8'h91 + k), k == 4);
        drive_sources();
        step();
        repeat (HDR) step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_sources();
        drive_sources();
        step();
        chk("t5_beats_before_rst", 32'(dlog.size()), 32'd2);
        chk("t5_busy_after_rst", 32'(busy_hist[cyc - 1]), 32'd0);
        push_beat(0, 8'hA0, 1'b1);
        push_beat(3, 8'hB3, 1'b1);
        drive_sources();
        repeat (8) step();
        chk("t5_count", 32'(dlog.size()), 32'd4);
        if (dlog.size() > 3) begin
            chk("t5_first_after_rst", 32'(dlog[2].id), 32'd0);
            chk("t5_second_after_rst", 32'(dlog[3].id), 32'd3);
        end

`ifdef UART_TX_ARB_HDR_EN
        // Header beat precedes the data of each grant
        do_reset();
        txs.delete();
        push_beat(2, 8'h55, 1'b1);
        drive_sources();
        repeat (6) step();
        chk("t6_count", 32'(txs.size()), 32'd2);
        if (txs.size() > 1) begin
            chk("t6_hdr", 32'(txs[0]), 32'h82);
            chk("t6_data", 32'(txs[1]), 32'h55);
        end
`endif

        // Randomized traffic with random valid gaps and backpressure
        do_reset();
        vrate = 60;
        rrate = 70;
        for (int n = 0; n < 1500; n++) begin
            int r;
            int len;
            if ($urandom_range(99) < 8) begin
                r   = int'($urandom_range(NREQ - 1));
                len = int'($urandom_range(7, 1));
                if (srcq[r].size() < 16)
                    for (int k = 0; k < len; k++) push_beat(r, 8'($urandom), k == len - 1);
            end
            step();
        end
        vrate = 100;
        rrate = 100;
        for (int n = 0; n < 600 && !all_empty(); n++) step();
        chk("drain_all_delivered", 32'(all_empty()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
